// File: rtl/nn_layer_engine.sv
// Time-multiplexed fully-connected layer: one shared signed fixed-point MAC walks every neuron.
// Define NN_LAYER_RELU_EN for clamped-ReLU activation; the default build uses a step activation.

`ifndef NN_DATA_WIDTH
`define NN_DATA_WIDTH 16
`endif

module nn_layer_engine #(
    parameter int DATA_WIDTH  = `NN_DATA_WIDTH,
    parameter int FRAC_BITS   = DATA_WIDTH / 2,
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 4
) (
    input  logic                                            clock,
    input  logic                                            resetn,
    input  logic                                            start,
    input  logic [DATA_WIDTH*INPUT_SIZE-1:0]                input_data,
    input  logic [DATA_WIDTH*OUTPUT_SIZE*(INPUT_SIZE+1)-1:0] weights,
    output logic                                            busy,
    output logic                                            done,
    output logic [DATA_WIDTH*OUTPUT_SIZE-1:0]               output_data
);

    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(INPUT_SIZE + 1);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int IW         = $clog2(INPUT_SIZE + 1);
    localparam int OW         = $clog2(OUTPUT_SIZE + 1);
    localparam logic [IW-1:0] I_LAST = IW'(INPUT_SIZE - 1);
    localparam logic [OW-1:0] J_LAST = OW'(OUTPUT_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ACT,
        S_DONE
    } state_t;

    state_t                           state_q, state_d;
    logic [IW-1:0]                    i_q, i_d;
    logic [OW-1:0]                    j_q, j_d;
    logic signed [ACC_WIDTH-1:0]      acc_q, acc_d;
    logic [DATA_WIDTH*INPUT_SIZE-1:0] in_q, in_d;
    logic [DATA_WIDTH*OUTPUT_SIZE-1:0] res_q, res_d;
    logic [DATA_WIDTH*OUTPUT_SIZE-1:0] out_q, out_d;

    int                               x_base;
    int                               w_base;
    int                               thr_base;
    int                               res_base;
    logic signed [DATA_WIDTH-1:0]     x_op;
    logic signed [DATA_WIDTH-1:0]     w_op;
    logic signed [DATA_WIDTH-1:0]     thr_op;
    logic signed [PROD_WIDTH-1:0]     prod;
    logic signed [PROD_WIDTH-1:0]     prod_sh;
    logic signed [ACC_WIDTH-1:0]      prod_ext;
    logic [DATA_WIDTH-1:0]            act_val;

    // Operand fetch for the current (neuron j, input i) pair and the shared multiplier.
    always_comb begin
        x_base   = int'(i_q) * DATA_WIDTH;
        w_base   = (int'(j_q) * (INPUT_SIZE + 1) + int'(i_q)) * DATA_WIDTH;
        thr_base = (int'(j_q) * (INPUT_SIZE + 1) + INPUT_SIZE) * DATA_WIDTH;
        res_base = int'(j_q) * DATA_WIDTH;
        x_op     = in_q[x_base +: DATA_WIDTH];
        w_op     = weights[w_base +: DATA_WIDTH];
        thr_op   = weights[thr_base +: DATA_WIDTH];
        prod     = x_op * w_op;
        prod_sh  = prod >>> FRAC_BITS;
        prod_ext = ACC_WIDTH'(prod_sh);
    end

`ifdef NN_LAYER_RELU_EN
    localparam logic signed [ACC_WIDTH:0] RELU_MAX =
        {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};

    logic signed [ACC_WIDTH:0] diff;

    // One extra bit keeps acc - thr exact before clamping into [0, max positive word].
    always_comb begin
        diff = (ACC_WIDTH + 1)'(acc_q) - (ACC_WIDTH + 1)'(thr_op);
        if (diff < 0) begin
            act_val = '0;
        end else if (diff > RELU_MAX) begin
            act_val = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else begin
            act_val = diff[DATA_WIDTH-1:0];
        end
    end
`else
    localparam logic [DATA_WIDTH-1:0] ACT_ONE = DATA_WIDTH'(1) << FRAC_BITS;

    logic signed [ACC_WIDTH-1:0] thr_ext;

    always_comb begin
        thr_ext = ACC_WIDTH'(thr_op);
        act_val = (acc_q >= thr_ext) ? ACT_ONE : '0;
    end
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        in_d    = in_q;
        res_d   = res_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    in_d    = input_data;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                if (i_q == I_LAST) begin
                    state_d = S_ACT;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_ACT: begin
                res_d[res_base +: DATA_WIDTH] = act_val;
                // All neurons land in output_data together so consumers never see a mixed layer.
                if (j_q == J_LAST) begin
                    out_d   = res_d;
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    i_d     = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            in_q    <= '0;
            res_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            in_q    <= in_d;
            res_q   <= res_d;
            out_q   <= out_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign output_data = out_q;

endmodule

// File: tb/tb_nn_layer_engine.sv
// Directed bench for nn_layer_engine: 2x2 main instance plus 1x1 and 8x3 corner instances.
// Expected values follow NN_LAYER_RELU_EN when it is defined for the build.

module tb_nn_layer_engine;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    // Main instance: IN=2, OUT=2
    logic         a_start;
    logic [31:0]  a_in;
    logic [95:0]  a_w;
    logic         a_busy, a_done;
    logic [31:0]  a_out;

    // Corner instance: IN=1, OUT=1
    logic         b_start;
    logic [15:0]  b_in;
    logic [31:0]  b_w;
    logic         b_busy, b_done;
    logic [15:0]  b_out;

    // Corner instance: IN=8, OUT=3
    logic         c_start;
    logic [127:0] c_in;
    logic [431:0] c_w;
    logic         c_busy, c_done;
    logic [47:0]  c_out;

    int n_compared;
    int n_mismatched;

`ifdef NN_LAYER_RELU_EN
    localparam logic [31:0] EXP_BASIC = {16'h0000, 16'h0080};
    localparam logic [31:0] EXP_SAT   = {16'h7FFF, 16'h7FFF};
    localparam logic [15:0] EXP_B_POS = 16'h0080;
`else
    localparam logic [31:0] EXP_BASIC = {16'h0000, 16'h0100};
    localparam logic [31:0] EXP_SAT   = {16'h0100, 16'h0100};
    localparam logic [15:0] EXP_B_POS = 16'h0100;
`endif

    nn_layer_engine #(.DATA_WIDTH(16), .INPUT_SIZE(2), .OUTPUT_SIZE(2)) dut_a (
        .clock(clock), .resetn(resetn), .start(a_start), .input_data(a_in),
        .weights(a_w), .busy(a_busy), .done(a_done), .output_data(a_out)
    );

    nn_layer_engine #(.DATA_WIDTH(16), .INPUT_SIZE(1), .OUTPUT_SIZE(1)) dut_b (
        .clock(clock), .resetn(resetn), .start(b_start), .input_data(b_in),
        .weights(b_w), .busy(b_busy), .done(b_done), .output_data(b_out)
    );

    nn_layer_engine #(.DATA_WIDTH(16), .INPUT_SIZE(8), .OUTPUT_SIZE(3)) dut_c (
        .clock(clock), .resetn(resetn), .start(c_start), .input_data(c_in),
        .weights(c_w), .busy(c_busy), .done(c_done), .output_data(c_out)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load_basic;
        a_in = {16'h0200, 16'h0100};
        a_w  = {16'h0000, 16'hFF00, 16'h0100, 16'h0100, 16'h0080, 16'h0080};
    endtask

    // Starts one run on the main instance and waits (bounded) for done; input_data is scrambled after acceptance.
    task automatic run_a(output int lat, output int busy_cnt, output bit early_change);
        logic [31:0] prev;
        a_start = 1'b1;
        tick();
        a_start      = 1'b0;
        a_in         = ~a_in;
        lat          = 0;
        busy_cnt     = 0;
        early_change = 1'b0;
        prev         = a_out;
        while (!a_done && lat < 40) begin
            if (a_busy) busy_cnt++;
            if (a_out !== prev) early_change = 1'b1;
            tick();
            lat++;
        end
        if (a_busy) busy_cnt++;
    endtask

    task automatic test_reset;
        resetn  = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        c_start = 1'b0;
        a_in = '0; a_w = '0; b_in = '0; b_w = '0; c_in = '0; c_w = '0;
        tick();
        tick();
        n_compared += 4;
        if (a_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", a_busy); end
        if (a_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", a_done); end
        if (a_out !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_out: got %h expected 0", a_out); end
        if ({b_busy, c_busy, b_done, c_done} !== 4'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_corner_flags: got %b expected 0000", {b_busy, c_busy, b_done, c_done});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int lat, busy_cnt;
        bit early;
        load_basic();
        run_a(lat, busy_cnt, early);
        n_compared += 4;
        if (lat !== 6) begin n_mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 6", lat); end
        if (a_out !== EXP_BASIC) begin n_mismatched++; $display("[TB] FAIL basic_out: got %h expected %h", a_out, EXP_BASIC); end
        if (busy_cnt !== 7) begin n_mismatched++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 7", busy_cnt); end
        if (early !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_out_early: got %b expected 0", early); end
        tick();
        n_compared += 2;
        if (a_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", a_done); end
        if (a_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_busy_after: got %b expected 0", a_busy); end
    endtask

    task automatic test_saturation;
        int lat, busy_cnt;
        bit early;
        a_in = {16'h7FFF, 16'h7FFF};
        a_w  = {16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
        run_a(lat, busy_cnt, early);
        n_compared += 2;
        if (a_out !== EXP_SAT) begin n_mismatched++; $display("[TB] FAIL sat_out: got %h expected %h", a_out, EXP_SAT); end
        if (lat !== 6) begin n_mismatched++; $display("[TB] FAIL sat_latency: got %0d expected 6", lat); end
        tick();
    endtask

    // Extra start pulses during MAC cycles and in the DONE cycle must all be ignored.
    task automatic test_handshake;
        int done_cnt;
        load_basic();
        a_start = 1'b1;
        tick();
        a_start  = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            a_start = (c == 3 || c == 5 || c == 7);
            tick();
            if (a_done) done_cnt++;
        end
        a_start = 1'b0;
        n_compared += 3;
        if (done_cnt !== 1) begin n_mismatched++; $display("[TB] FAIL hs_done_count: got %0d expected 1", done_cnt); end
        if (a_out !== EXP_BASIC) begin n_mismatched++; $display("[TB] FAIL hs_out: got %h expected %h", a_out, EXP_BASIC); end
        if (a_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hs_idle: got %b expected 0", a_busy); end
    endtask

    // Start held high: seven non-done cycles separate the two done pulses.
    task automatic test_back_to_back;
        int lat, gap;
        load_basic();
        a_start = 1'b1;
        tick();
        lat = 0;
        while (!a_done && lat < 40) begin tick(); lat++; end
        gap = 0;
        do begin tick(); gap++; end while (!a_done && gap < 40);
        a_start = 1'b0;
        n_compared += 3;
        if (lat !== 6) begin n_mismatched++; $display("[TB] FAIL b2b_first_latency: got %0d expected 6", lat); end
        if (gap !== 8) begin n_mismatched++; $display("[TB] FAIL b2b_done_spacing: got %0d expected 8", gap); end
        if (a_out !== EXP_BASIC) begin n_mismatched++; $display("[TB] FAIL b2b_out: got %h expected %h", a_out, EXP_BASIC); end
        tick();
        tick();
    endtask

    task automatic test_reset_midrun;
        int lat, busy_cnt, seen_done;
        bit early;
        load_basic();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick(); tick(); tick();
        resetn = 1'b0;
        #1;
        n_compared += 3;
        if (a_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", a_busy); end
        if (a_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_done: got %b expected 0", a_done); end
        if (a_out !== 32'h0) begin n_mismatched++; $display("[TB] FAIL midrst_out: got %h expected 0", a_out); end
        tick();
        resetn = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (a_done || a_busy) seen_done++;
        end
        n_compared++;
        if (seen_done !== 0) begin n_mismatched++; $display("[TB] FAIL midrst_no_activity: got %0d expected 0", seen_done); end
        load_basic();
        run_a(lat, busy_cnt, early);
        n_compared += 2;
        if (a_out !== EXP_BASIC) begin n_mismatched++; $display("[TB] FAIL midrst_rerun_out: got %h expected %h", a_out, EXP_BASIC); end
        if (lat !== 6) begin n_mismatched++; $display("[TB] FAIL midrst_rerun_latency: got %0d expected 6", lat); end
        tick();
    endtask

    task automatic test_corner_1x1;
        int lat;
        // 3.0 * 0.5 = 1.5 against threshold 1.0
        b_in = 16'h0300;
        b_w  = {16'h0100, 16'h0080};
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        lat = 0;
        while (!b_done && lat < 40) begin tick(); lat++; end
        n_compared += 2;
        if (lat !== 2) begin n_mismatched++; $display("[TB] FAIL c11_latency: got %0d expected 2", lat); end
        if (b_out !== EXP_B_POS) begin n_mismatched++; $display("[TB] FAIL c11_pos_out: got %h expected %h", b_out, EXP_B_POS); end
        tick();
        // -1.0 * 2.0 = -2.0 against threshold -1.0: below in both modes
        b_in = 16'hFF00;
        b_w  = {16'hFF00, 16'h0200};
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        lat = 0;
        while (!b_done && lat < 40) begin tick(); lat++; end
        n_compared += 2;
        if (lat !== 2) begin n_mismatched++; $display("[TB] FAIL c11_neg_latency: got %0d expected 2", lat); end
        if (b_out !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL c11_neg_out: got %h expected 0000", b_out); end
        tick();
    endtask

    task automatic test_corner_8x3;
        int lat;
        longint acc, a, w, thr, d;
        logic [15:0] exp_val;
        logic [127:0] in_snapshot;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 8; k++) c_in[k*16 +: 16] = 16'($urandom);
            for (int k = 0; k < 27; k++) c_w[k*16 +: 16] = 16'($urandom);
            in_snapshot = c_in;
            c_start = 1'b1;
            tick();
            c_start = 1'b0;
            c_in    = ~c_in;
            lat = 0;
            while (!c_done && lat < 100) begin tick(); lat++; end
            n_compared++;
            if (lat !== 27) begin n_mismatched++; $display("[TB] FAIL c83_latency: got %0d expected 27", lat); end
            for (int j = 0; j < 3; j++) begin
                acc = 0;
                for (int i = 0; i < 8; i++) begin
                    a = longint'($signed(in_snapshot[i*16 +: 16]));
                    w = longint'($signed(c_w[(j*9 + i)*16 +: 16]));
                    acc += (a * w) >>> 8;
                end
                thr = longint'($signed(c_w[(j*9 + 8)*16 +: 16]));
`ifdef NN_LAYER_RELU_EN
                d = acc - thr;
                if (d < 0) exp_val = 16'h0000;
                else if (d > 32767) exp_val = 16'h7FFF;
                else exp_val = 16'(d);
`else
                d = 0;
                exp_val = (acc >= thr) ? 16'h0100 : 16'h0000;
`endif
                n_compared++;
                if (c_out[j*16 +: 16] !== exp_val) begin
                    n_mismatched++;
                    $display("[TB] FAIL c83_neuron%0d: got %h expected %h (d=%0d)", j, c_out[j*16 +: 16], exp_val, d);
                end
            end
            tick();
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_handshake();
        test_back_to_back();
        test_reset_midrun();
        test_corner_1x1();
        test_corner_8x3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
